// File: rtl/ahbmtx_in_stg.sv
// Bus-matrix input stage: forwards or holds a master's address phase until granted,
// then tracks the data phase to drive the master's ready and response.
module ahbmtx_in_stg #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  output logic                  HREADYOUTS,
  output logic [1:0]            HRESPS,
  output logic                  req_port,
  output logic                  sel_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [1:0]            trans_o,
  output logic                  write_o,
  output logic [2:0]            size_o,
  output logic [2:0]            burst_o,
  output logic [3:0]            prot_o,
  output logic                  lock_o,
  input  logic                  addr_active,
  input  logic                  hready_m,
  input  logic                  hready_dp,
  input  logic [1:0]            hresp_dp
);

  logic                  w_live_req;
  logic                  w_accept;
  logic                  r_pend;
  logic                  r_dphase;
  logic                  r_sel;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_trans;
  logic                  r_write;
  logic [2:0]            r_size;
  logic [2:0]            r_burst;
  logic [3:0]            r_prot;
  logic                  r_lock;

  // A request seen while reset is asserted is dropped so outputs stay at reset values.
  assign w_live_req = ~HRESET & HSELS & HREADYS & HTRANSS[1];
  assign w_accept   = (w_live_req | r_pend) & addr_active & hready_m;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_sel   <= 1'b0;
      r_addr  <= '0;
      r_trans <= 2'b00;
      r_write <= 1'b0;
      r_size  <= 3'b000;
      r_burst <= 3'b000;
      r_prot  <= 4'b0000;
      r_lock  <= 1'b0;
    end else if (HREADYS && !r_pend) begin
      // Never overwrite a held transfer while it waits for a grant.
      r_sel   <= HSELS;
      r_addr  <= HADDRS;
      r_trans <= HTRANSS;
      r_write <= HWRITES;
      r_size  <= HSIZES;
      r_burst <= HBURSTS;
      r_prot  <= HPROTS;
      r_lock  <= HMASTLOCKS;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_pend   <= 1'b0;
      r_dphase <= 1'b0;
    end else begin
      if (w_live_req && !w_accept) begin
        r_pend <= 1'b1;
      end else if (w_accept) begin
        r_pend <= 1'b0;
      end
      // Accept wins over completion so back-to-back transfers keep dphase set.
      if (w_accept) begin
        r_dphase <= 1'b1;
      end else if (hready_dp) begin
        r_dphase <= 1'b0;
      end
    end
  end

  always_comb begin
    sel_o      = r_pend ? r_sel   : HSELS;
    addr_o     = r_pend ? r_addr  : HADDRS;
    write_o    = r_pend ? r_write : HWRITES;
    size_o     = r_pend ? r_size  : HSIZES;
    burst_o    = r_pend ? r_burst : HBURSTS;
    prot_o     = r_pend ? r_prot  : HPROTS;
    lock_o     = r_pend ? r_lock  : HMASTLOCKS;
    trans_o    = r_pend ? r_trans : (w_live_req ? HTRANSS : 2'b00);
    req_port   = w_live_req | r_pend;
    HREADYOUTS = r_pend ? 1'b0 : (r_dphase ? hready_dp : 1'b1);
    HRESPS     = r_dphase ? hresp_dp : 2'b00;
  end

endmodule

// File: tb/tb_ahbmtx_in_stg.sv
// Self-checking bench for ahbmtx_in_stg: directed cycles plus a scoreboard of
// address phases expected to be accepted by the output stage.
module tb_ahbmtx_in_stg;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;
  logic        req_port;
  logic        sel_o;
  logic [31:0] addr_o;
  logic [1:0]  trans_o;
  logic        write_o;
  logic [2:0]  size_o;
  logic [2:0]  burst_o;
  logic [3:0]  prot_o;
  logic        lock_o;
  logic        addr_active;
  logic        hready_m;
  logic        hready_dp;
  logic [1:0]  hresp_dp;
  logic        r_block;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  logic [63:0] sb_q[$];

  // The master sees its own ready; r_block models another stall source.
  assign HREADYS = HREADYOUTS & ~r_block;

  always #5 HCLK = ~HCLK;

  ahbmtx_in_stg #(.ADDR_WIDTH(32)) u_dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HSELS       (HSELS),
    .HADDRS      (HADDRS),
    .HTRANSS     (HTRANSS),
    .HWRITES     (HWRITES),
    .HSIZES      (HSIZES),
    .HBURSTS     (HBURSTS),
    .HPROTS      (HPROTS),
    .HMASTLOCKS  (HMASTLOCKS),
    .HREADYS     (HREADYS),
    .HREADYOUTS  (HREADYOUTS),
    .HRESPS      (HRESPS),
    .req_port    (req_port),
    .sel_o       (sel_o),
    .addr_o      (addr_o),
    .trans_o     (trans_o),
    .write_o     (write_o),
    .size_o      (size_o),
    .burst_o     (burst_o),
    .prot_o      (prot_o),
    .lock_o      (lock_o),
    .addr_active (addr_active),
    .hready_m    (hready_m),
    .hready_dp   (hready_dp),
    .hresp_dp    (hresp_dp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle();
    HSELS      = 1'b0;
    HADDRS     = 32'h0;
    HTRANSS    = 2'b00;
    HWRITES    = 1'b0;
    HSIZES     = 3'b010;
    HBURSTS    = 3'b000;
    HPROTS     = 4'b0011;
    HMASTLOCKS = 1'b0;
  endtask

  task automatic xfer(input logic [31:0] a, input logic [1:0] t, input logic w, input logic push);
    HSELS   = 1'b1;
    HADDRS  = a;
    HTRANSS = t;
    HWRITES = w;
    if (push) sb_q.push_back({29'b0, w, t, a});
  endtask

  // Accept = grant while requesting; compare what the output stage sees.
  always @(negedge HCLK) begin
    if (HRESET === 1'b0 && req_port === 1'b1 && addr_active === 1'b1 && hready_m === 1'b1) begin
      n_acc++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_accept", {29'b0, write_o, trans_o, addr_o}, 64'h0);
      end else begin
        chk("sb_addr_phase", {29'b0, write_o, trans_o, addr_o}, sb_q.pop_front());
      end
    end
  end

  initial begin
    logic [1:0]  b_trans [6];
    logic [31:0] b_addr  [6];
    logic        b_dp    [6];
    logic        b_acc   [6];
    int          n_lo;
    int          acc0;

    b_trans = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    b_addr  = '{32'h1000, 32'h1004, 32'h1008, 32'h1008, 32'h100C, 32'h0};
    b_dp    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    b_acc   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    idle();
    r_block     = 1'b0;
    addr_active = 1'b0;
    hready_m    = 1'b0;
    hready_dp   = 1'b1;
    hresp_dp    = 2'b00;
    HRESET      = 1'b1;
    HSELS       = 1'b1;
    HTRANSS     = 2'b10;

    // Reset held two cycles with a NONSEQ presented
    tick();
    tick();
    #2;
    chk("rst_hreadyout", 64'(HREADYOUTS), 64'd1);
    chk("rst_hresp", 64'(HRESPS), 64'd0);
    chk("rst_req", 64'(req_port), 64'd0);
    chk("rst_trans", 64'(trans_o), 64'd0);

    tick();
    HRESET = 1'b0;
    idle();
    addr_active = 1'b1;
    hready_m    = 1'b1;

    // Zero-wait forward of a NONSEQ write
    tick();
    xfer(32'h2000_0040, 2'b10, 1'b1, 1'b1);
    #2;
    chk("zw_addr", 64'(addr_o), 64'h2000_0040);
    chk("zw_req", 64'(req_port), 64'd1);
    chk("zw_hreadyout", 64'(HREADYOUTS), 64'd1);
    tick();
    idle();
    hready_dp = 1'b0;
    #2;
    chk("zw_dp_wait", 64'(HREADYOUTS), 64'd0);
    tick();
    hready_dp = 1'b1;
    #2;
    chk("zw_dp_ready", 64'(HREADYOUTS), 64'd1);
    tick();
    hready_dp = 1'b0;
    #2;
    chk("zw_dp_done", 64'(HREADYOUTS), 64'd1);
    hready_dp = 1'b1;

    // Held NONSEQ read, granted after three cycles
    tick();
    addr_active = 1'b0;
    xfer(32'h4000_0010, 2'b10, 1'b0, 1'b1);
    #2;
    chk("hold_req", 64'(req_port), 64'd1);
    chk("hold_first_rdy", 64'(HREADYOUTS), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      HADDRS      = 32'hFFFF_FFFF;
      addr_active = (i == 2);
      #2;
      chk("hold_stall", 64'(HREADYOUTS), 64'd0);
      chk("hold_addr", 64'(addr_o), 64'h4000_0010);
    end
    tick();
    idle();
    addr_active = 1'b1;
    #2;
    chk("hold_release_rdy", 64'(HREADYOUTS), 64'd1);
    chk("hold_release_req", 64'(req_port), 64'd0);

    // IDLE and BUSY raise no request
    tick();
    HSELS   = 1'b1;
    HADDRS  = 32'h7000_0000;
    HTRANSS = 2'b00;
    #2;
    chk("idle_req", 64'(req_port), 64'd0);
    chk("idle_trans", 64'(trans_o), 64'd0);
    tick();
    HTRANSS   = 2'b01;
    hready_dp = 1'b0;
    #2;
    chk("busy_req", 64'(req_port), 64'd0);
    chk("busy_no_dphase", 64'(HREADYOUTS), 64'd1);
    tick();
    idle();
    hready_dp = 1'b1;

    // INCR4 burst with one data-phase wait on beat 2
    n_lo = 0;
    acc0 = n_acc;
    HBURSTS = 3'b011;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (b_trans[i] == 2'b00) idle();
      else xfer(b_addr[i], b_trans[i], 1'b1, b_acc[i]);
      hready_dp = b_dp[i];
      #2;
      if (HREADYOUTS !== 1'b1) n_lo++;
    end
    chk("burst_low_cycles", 64'(n_lo), 64'd1);
    tick();
    hready_dp = 1'b0;
    #2;
    chk("burst_dphase_clr", 64'(HREADYOUTS), 64'd1);
    chk("burst_accepts", 64'(n_acc - acc0), 64'd4);
    hready_dp = 1'b1;

    // Two-cycle ERROR response
    tick();
    xfer(32'h3000_0000, 2'b10, 1'b1, 1'b1);
    tick();
    idle();
    hready_dp = 1'b0;
    hresp_dp  = 2'b01;
    #2;
    chk("err1_rdy", 64'(HREADYOUTS), 64'd0);
    chk("err1_resp", 64'(HRESPS), 64'd1);
    tick();
    hready_dp = 1'b1;
    HSELS     = 1'b1;
    HTRANSS   = 2'b00;
    #2;
    chk("err2_rdy", 64'(HREADYOUTS), 64'd1);
    chk("err2_resp", 64'(HRESPS), 64'd1);
    chk("err2_idle_req", 64'(req_port), 64'd0);
    tick();
    idle();
    hresp_dp = 2'b00;
    #2;
    chk("err_done_resp", 64'(HRESPS), 64'd0);

    // HREADYS low: no request even with a NONSEQ presented
    tick();
    r_block = 1'b1;
    xfer(32'h6000_0000, 2'b10, 1'b0, 1'b0);
    #2;
    chk("nrdy_req", 64'(req_port), 64'd0);
    chk("nrdy_trans", 64'(trans_o), 64'd0);
    tick();
    r_block = 1'b0;
    idle();

    // Reset while a transfer is held discards it
    tick();
    addr_active = 1'b0;
    xfer(32'h5000_0000, 2'b10, 1'b0, 1'b0);
    tick();
    idle();
    HRESET = 1'b1;
    #2;
    chk("rstp_pending", 64'(HREADYOUTS), 64'd0);
    tick();
    HRESET = 1'b0;
    #2;
    chk("rstp_rdy", 64'(HREADYOUTS), 64'd1);
    chk("rstp_req", 64'(req_port), 64'd0);
    chk("rstp_trans", 64'(trans_o), 64'd0);
    chk("rstp_addr", 64'(addr_o), 64'd0);

    // Reset during a data phase
    addr_active = 1'b1;
    tick();
    xfer(32'h5000_0100, 2'b10, 1'b1, 1'b1);
    tick();
    idle();
    HRESET    = 1'b1;
    hready_dp = 1'b0;
    hresp_dp  = 2'b01;
    tick();
    HRESET = 1'b0;
    #2;
    chk("rstd_rdy", 64'(HREADYOUTS), 64'd1);
    chk("rstd_resp", 64'(HRESPS), 64'd0);

    tick();
    chk("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
